uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Detects the start condition on the serial line and owns the oversampling edge counter and the bit counter.
- Issues single-cycle enables to the sampler, start checker, deserializer, parity checker and stop checker, evaluates their registered error flags, and pulses a data-valid or frame-error result per frame.
- Sits between the serial input pin and the RX checker/deserializer datapath.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the prescale input and edge counter.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous active-low reset
- i_rx_in  input  1  serial line, idle high
- i_prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- i_par_en  input  1  parity bit present in frame
- i_strt_glitch  input  1  registered start-check result, 1 = start bit sampled high
- i_par_err  input  1  registered parity-check result
- i_stp_err  input  1  registered stop-check result
- o_dat_samp_en  output  1  sampler enable
- o_edge_cnt  output  PRESCALE_W  current oversample edge within bit, 0..P-1
- o_bit_cnt  output  4  data bit index, 0..DATA_WIDTH-1
- o_strt_chk_en  output  1  start-check enable pulse
- o_deser_en  output  1  deserializer shift enable pulse
- o_par_chk_en  output  1  parity-check enable pulse
- o_stp_chk_en  output  1  stop-check enable pulse
- o_data_valid  output  1  frame received without error, 1-cycle pulse
- o_frm_err  output  1  frame rejected (parity or stop error), 1-cycle pulse

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; latched prescale = 8; parity-error latch cleared. Reset mid-frame aborts to IDLE with no pulses.
- Prescale latch: P is latched from i_prescale in the IDLE→START cycle and held for the whole frame. Any value other than 8/16/32 latches as 8. Changes to i_prescale mid-frame are ignored.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - i_rx_in=0 in a cycle → START. That cycle counts as edge 0, so o_edge_cnt=1 in the first START cycle.
  - Otherwise edge_cnt=0 and bit_cnt=0.
- Edge counter:
  - In all non-IDLE states, increments each cycle.
  - Wraps P-1 → 0 at every bit boundary.
- o_dat_samp_en: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Check/shift enables:
  - Each is a 1-cycle pulse at edge_cnt == P-2 of its own bit: strt_chk in START, deser in DATA, par_chk in PARITY, stp_chk in STOP.
  - The checker flag is registered and is evaluated at edge_cnt == P-1.
- START at edge P-1:
  - i_strt_glitch=1 → IDLE, no pulses.
  - Otherwise → DATA with bit_cnt=0.
- DATA at edge P-1:
  - bit_cnt < DATA_WIDTH-1 → bit_cnt+1, stay in DATA.
  - bit_cnt == DATA_WIDTH-1 → PARITY if i_par_en, else STOP. i_par_en is sampled at this point.
- PARITY at edge P-1: latch i_par_err into the sticky parity-error latch; → STOP unconditionally.
- STOP at edge P-1: → IDLE. In the following cycle exactly one of these is registered high for 1 cycle:
  - o_data_valid, when (parity latch | i_stp_err) == 0;
  - o_frm_err, otherwise.
  - The parity latch clears on entry to IDLE.
- Back-to-back frames:
  - i_rx_in=0 in the first IDLE cycle after STOP starts a new frame immediately.
  - The result pulse of the previous frame still occurs.
- Line held low in IDLE (break condition): each P-cycle start attempt with low start bit proceeds as a normal frame. The frame ends with o_frm_err because the stop bit samples 0.
- Enables are never asserted in IDLE. No two check/shift enables are ever high in the same cycle.

Test Plan:
- Reset, P=8, no parity, send 0xA5 LSB-first with valid start/stop; T0 = first cycle rx low in IDLE → o_deser_en pulses 8 times at T0+14+8k (k=0..7), o_data_valid=1 only at T0+80, o_frm_err stays 0.
- P=16, parity on, good parity on 0x3C → o_par_chk_en once at T0+158, o_stp_chk_en once at T0+174, o_data_valid at T0+176.
- P=8, rx low for 3 cycles then high (i_strt_glitch=1 at edge 7) → state IDLE at T0+8, no enables after strt_chk, no pulses.
- P=8, parity on, i_par_err=1 at parity edge 7 with good stop bit → o_frm_err=1 at T0+88, o_data_valid stays 0.
- P=8, no parity, stop bit driven 0 (i_stp_err=1) → o_frm_err at T0+80; a second good frame starting at T0+80 → o_data_valid at T0+160.
- Assert i_rst low during DATA bit 3 → all outputs 0 immediately, state IDLE. Change i_prescale mid-frame → frame timing unchanged. i_prescale=12 → behaves as P=8.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, oversample edge/bit counting,
// single-cycle checker/deserializer enables and per-frame result pulses.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_in,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic                  i_par_en,
    input  logic                  i_strt_glitch,
    input  logic                  i_par_err,
    input  logic                  i_stp_err,
    output logic                  o_dat_samp_en,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [3:0]            o_bit_cnt,
    output logic                  o_strt_chk_en,
    output logic                  o_deser_en,
    output logic                  o_par_chk_en,
    output logic                  o_stp_chk_en,
    output logic                  o_data_valid,
    output logic                  o_frm_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);
    localparam logic [PRESCALE_W-1:0] P8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] P32 = PRESCALE_W'(32);
    localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                  state, state_nx;
    logic [PRESCALE_W-1:0]   p_lat, p_nx, p_sel, edge_nx;
    logic [3:0]              bit_nx;
    logic                    par_lat;
    logic                    last_edge;
    logic                    chk_edge;
    logic                    frame_bad;

    assign p_sel     = (i_prescale == P16 || i_prescale == P32) ? i_prescale : P8;
    assign last_edge = (o_edge_cnt == p_lat - ONE);
    assign frame_bad = par_lat | i_stp_err;

    always_comb begin
        state_nx = state;
        p_nx     = p_lat;
        edge_nx  = o_edge_cnt + ONE;
        bit_nx   = o_bit_cnt;
        case (state)
            IDLE: begin
                bit_nx = '0;
                if (!i_rx_in) begin
                    // The detecting cycle is edge 0, so the first START cycle shows edge 1.
                    state_nx = START;
                    p_nx     = p_sel;
                    edge_nx  = ONE;
                end else begin
                    edge_nx = '0;
                end
            end
            START: begin
                if (last_edge) begin
                    edge_nx  = '0;
                    bit_nx   = '0;
                    state_nx = i_strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_edge) begin
                    edge_nx = '0;
                    if (o_bit_cnt == LAST_BIT) begin
                        state_nx = i_par_en ? PARITY : STOP;
                    end else begin
                        bit_nx = o_bit_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    edge_nx  = '0;
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    edge_nx  = '0;
                    bit_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                edge_nx  = '0;
                bit_nx   = '0;
            end
        endcase
    end

    // Enables are registered from next-state values so they line up with edge P-2.
    assign chk_edge = (edge_nx == p_nx - TWO);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            p_lat         <= P8;
            par_lat       <= 1'b0;
            o_dat_samp_en <= 1'b0;
            o_edge_cnt    <= '0;
            o_bit_cnt     <= '0;
            o_strt_chk_en <= 1'b0;
            o_deser_en    <= 1'b0;
            o_par_chk_en  <= 1'b0;
            o_stp_chk_en  <= 1'b0;
            o_data_valid  <= 1'b0;
            o_frm_err     <= 1'b0;
        end else begin
            state         <= state_nx;
            p_lat         <= p_nx;
            o_edge_cnt    <= edge_nx;
            o_bit_cnt     <= bit_nx;
            o_dat_samp_en <= (state_nx != IDLE);
            o_strt_chk_en <= (state_nx == START)  && chk_edge;
            o_deser_en    <= (state_nx == DATA)   && chk_edge;
            o_par_chk_en  <= (state_nx == PARITY) && chk_edge;
            o_stp_chk_en  <= (state_nx == STOP)   && chk_edge;
            o_data_valid  <= (state == STOP) && last_edge && !frame_bad;
            o_frm_err     <= (state == STOP) && last_edge && frame_bad;
            if (state_nx == IDLE) begin
                par_lat <= 1'b0;
            end else if (state == PARITY && last_edge) begin
                par_lat <= par_lat | i_par_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl; a frame-level timing model predicts
// every output each cycle, with literal pulse-time pins on directed frames.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_rx_in;
    logic [PW-1:0] i_prescale;
    logic          i_par_en;
    logic          i_strt_glitch;
    logic          i_par_err;
    logic          i_stp_err;
    logic          o_dat_samp_en;
    logic [PW-1:0] o_edge_cnt;
    logic [3:0]    o_bit_cnt;
    logic          o_strt_chk_en;
    logic          o_deser_en;
    logic          o_par_chk_en;
    logic          o_stp_chk_en;
    logic          o_data_valid;
    logic          o_frm_err;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_rx_in(i_rx_in),
        .i_prescale(i_prescale),
        .i_par_en(i_par_en),
        .i_strt_glitch(i_strt_glitch),
        .i_par_err(i_par_err),
        .i_stp_err(i_stp_err),
        .o_dat_samp_en(o_dat_samp_en),
        .o_edge_cnt(o_edge_cnt),
        .o_bit_cnt(o_bit_cnt),
        .o_strt_chk_en(o_strt_chk_en),
        .o_deser_en(o_deser_en),
        .o_par_chk_en(o_par_chk_en),
        .o_stp_chk_en(o_stp_chk_en),
        .o_data_valid(o_data_valid),
        .o_frm_err(o_frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // A frame is fully described by its start cycle, prescale, bit count and outcome.
    typedef struct {
        bit v;
        int t0;
        int p;
        int nb;
        bit gl;
        bit bad;
    } frame_t;

    frame_t cur;
    frame_t prv;

    int q_strt[$];
    int q_deser[$];
    int q_par[$];
    int q_stp[$];
    int q_val[$];
    int q_ferr[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int d, len, b;
        int e_edge, e_bit;
        bit bit_known;
        bit e_samp, e_strt, e_deser, e_par, e_stp, e_val, e_ferr;
        e_edge = 0; e_bit = 0; bit_known = 1'b1;
        e_samp = 0; e_strt = 0; e_deser = 0; e_par = 0; e_stp = 0; e_val = 0; e_ferr = 0;
        if (cur.v) begin
            d   = cyc - cur.t0;
            len = cur.gl ? cur.p : cur.nb * cur.p;
            if (d > 0 && d < len) begin
                e_samp = 1'b1;
                e_edge = d % cur.p;
                b      = d / cur.p;
                if (b == 0)       e_bit = 0;
                else if (b <= DW) e_bit = b - 1;
                else              bit_known = 1'b0;
                if (e_edge == cur.p - 2) begin
                    if (b == 0)                              e_strt  = 1'b1;
                    else if (b <= DW)                        e_deser = 1'b1;
                    else if (b == DW + 1 && cur.nb == DW + 3) e_par   = 1'b1;
                    else                                     e_stp   = 1'b1;
                end
            end
            if (!cur.gl && d == len) begin
                e_val  = !cur.bad;
                e_ferr = cur.bad;
            end
        end
        if (prv.v && !prv.gl && cyc == prv.t0 + prv.nb * prv.p) begin
            e_val  = !prv.bad;
            e_ferr = prv.bad;
        end
        chk("samp_en",  int'(o_dat_samp_en), int'(e_samp));
        chk("edge_cnt", int'(o_edge_cnt),    e_edge);
        if (bit_known) chk("bit_cnt", int'(o_bit_cnt), e_bit);
        chk("strt_chk_en", int'(o_strt_chk_en), int'(e_strt));
        chk("deser_en",    int'(o_deser_en),    int'(e_deser));
        chk("par_chk_en",  int'(o_par_chk_en),  int'(e_par));
        chk("stp_chk_en",  int'(o_stp_chk_en),  int'(e_stp));
        chk("data_valid",  int'(o_data_valid),  int'(e_val));
        chk("frm_err",     int'(o_frm_err),     int'(e_ferr));
        if (o_strt_chk_en) q_strt.push_back(cyc);
        if (o_deser_en)    q_deser.push_back(cyc);
        if (o_par_chk_en)  q_par.push_back(cyc);
        if (o_stp_chk_en)  q_stp.push_back(cyc);
        if (o_data_valid)  q_val.push_back(cyc);
        if (o_frm_err)     q_ferr.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clrq();
        q_strt.delete(); q_deser.delete(); q_par.delete();
        q_stp.delete();  q_val.delete();   q_ferr.delete();
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_samp"},  int'(o_dat_samp_en), 0);
        chk({pfx, "_edge"},  int'(o_edge_cnt),    0);
        chk({pfx, "_bit"},   int'(o_bit_cnt),     0);
        chk({pfx, "_strt"},  int'(o_strt_chk_en), 0);
        chk({pfx, "_deser"}, int'(o_deser_en),    0);
        chk({pfx, "_par"},   int'(o_par_chk_en),  0);
        chk({pfx, "_stp"},   int'(o_stp_chk_en),  0);
        chk({pfx, "_valid"}, int'(o_data_valid),  0);
        chk({pfx, "_ferr"},  int'(o_frm_err),     0);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        cur.v = 1'b0;
        prv.v = 1'b0;
        i_rx_in = 1'b1;
        step();
        step();
        i_rst = 1'b1;
    endtask

    // Drives one frame on the line; the task returns in the cycle right after the stop bit.
    task automatic send_frame(input int gap, input int pre, input bit par, input logic [7:0] data,
                              input bit perr, input bit serr, input bit gl, input int abort_d,
                              input bit jit, output int t0);
        int p, len;
        logic [10:0] bits;
        repeat (gap) begin
            i_rx_in = 1'b1;
            step();
        end
        p = (pre == 16 || pre == 32) ? pre : 8;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (par) begin
            bits[9]  = ^data ^ perr;
            bits[10] = ~serr;
        end else begin
            bits[9]  = ~serr;
            bits[10] = 1'b1;
        end
        prv     = cur;
        cur.v   = 1'b1;
        cur.t0  = cyc;
        cur.p   = p;
        cur.nb  = par ? DW + 3 : DW + 2;
        cur.gl  = gl;
        cur.bad = (par && perr) || serr;
        t0  = cyc;
        len = gl ? p : cur.nb * p;
        i_prescale    = PW'(pre);
        i_par_en      = par;
        i_par_err     = perr;
        i_stp_err     = serr;
        i_strt_glitch = gl;
        for (int d = 0; d < len; d++) begin
            if (d == abort_d) begin
                do_reset();
                return;
            end
            i_rx_in = gl ? (d >= 3) : bits[d / p];
            if (jit && d > 0) i_prescale = PW'($urandom_range(0, 63));
            step();
        end
        i_rx_in = 1'b1;
    endtask

    task automatic pin1(input string nm, input int sz, input int first, input int t0, input int off);
        chk({nm, "_count"}, sz, 1);
        if (sz == 1) chk(nm, first - t0, off);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, t0b, pre;
        cur.v = 1'b0;
        prv.v = 1'b0;
        i_rst = 1'b1; i_rx_in = 1'b1; i_prescale = PW'(8); i_par_en = 1'b0;
        i_strt_glitch = 1'b0; i_par_err = 1'b0; i_stp_err = 1'b0;
        #1 i_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        i_rst = 1'b1;
        step();

        // P=8, no parity, 0xA5
        clrq();
        send_frame(2, 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, 1'b0, t0);
        step();
        chk("t1_deser_count", q_deser.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < q_deser.size()) chk("t1_deser_time", q_deser[k] - t0, 14 + 8 * k);
        pin1("t1_valid", q_val.size(), q_val.size() > 0 ? q_val[0] : 0, t0, 80);
        chk("t1_ferr_count", q_ferr.size(), 0);

        // P=16, parity on, good frame 0x3C
        clrq();
        send_frame(1, 16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0, t0);
        step();
        pin1("t2_par", q_par.size(), q_par.size() > 0 ? q_par[0] : 0, t0, 158);
        pin1("t2_stp", q_stp.size(), q_stp.size() > 0 ? q_stp[0] : 0, t0, 174);
        pin1("t2_valid", q_val.size(), q_val.size() > 0 ? q_val[0] : 0, t0, 176);

        // P=8 start glitch
        clrq();
        send_frame(1, 8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
        chk("t3_samp_idle", int'(o_dat_samp_en), 0);
        step();
        pin1("t3_strt", q_strt.size(), q_strt.size() > 0 ? q_strt[0] : 0, t0, 6);
        chk("t3_deser_count", q_deser.size(), 0);
        chk("t3_result_count", q_val.size() + q_ferr.size(), 0);

        // P=8, parity error with good stop
        clrq();
        send_frame(2, 8, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, -1, 1'b0, t0);
        step();
        pin1("t4_ferr", q_ferr.size(), q_ferr.size() > 0 ? q_ferr[0] : 0, t0, 88);
        chk("t4_valid_count", q_val.size(), 0);

        // Stop error, then a good frame back-to-back
        clrq();
        send_frame(1, 8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, -1, 1'b0, t0);
        send_frame(0, 8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, -1, 1'b0, t0b);
        step();
        pin1("t5_ferr", q_ferr.size(), q_ferr.size() > 0 ? q_ferr[0] : 0, t0, 80);
        pin1("t5_valid", q_val.size(), q_val.size() > 0 ? q_val[0] : 0, t0, 160);

        // Reset during DATA bit 3, then illegal prescale with mid-frame jitter
        send_frame(1, 16, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 16 * 4 + 3, 1'b0, t0);
        clrq();
        send_frame(1, 12, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, -1, 1'b1, t0);
        step();
        pin1("t6_valid", q_val.size(), q_val.size() > 0 ? q_val[0] : 0, t0, 80);
        chk("t6_deser_first", q_deser.size() > 0 ? q_deser[0] - t0 : -1, 14);

        // Break condition: line low, every attempt ends in a frame error
        clrq();
        send_frame(1, 8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, -1, 1'b0, t0);
        send_frame(0, 8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, -1, 1'b0, t0b);
        step();
        chk("t7_ferr_count", q_ferr.size(), 2);

        repeat (40) begin
            case ($urandom_range(0, 3))
                0:       pre = 8;
                1:       pre = 16;
                2:       pre = 32;
                default: pre = int'($urandom_range(0, 63));
            endcase
            send_frame(int'($urandom_range(0, 3)), pre, 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                       -1, 1'b1, t0);
        end
        i_rx_in = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
